// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS tone generator and its sweep controller.
//   INC_W       : phase-increment / frequency word width. It matches the
//                 1024-entry sine table, so the tone generator uses it too.
//   DWELL_W     : width of the per-frequency dwell count
//   state_e     : sweep controller state encoding (ST_IDLE, ST_UP, ST_DOWN)
//   MODE_SINGLE : single up-sweep, then stop
//   MODE_CONT   : continuous up/down triangle sweep
// -----------------------------------------------------------------------------
package dds_pkg;

   localparam int INC_W   = 10;
   localparam int DWELL_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } state_e;

   localparam logic MODE_SINGLE = 1'b0;
   localparam logic MODE_CONT   = 1'b1;

endpackage : dds_pkg

// File: rtl/dds_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl_if
// Control/config/status bundle between a sweep requester (switches, keys or a
// register block) and the sweep controller.
//   start, stop        : sweep commands from the requester
//   cfg_mode           : MODE_SINGLE / MODE_CONT
//   cfg_f_start/stop   : first and last phase increment
//   cfg_f_step         : increment between frequencies
//   cfg_dwell          : each frequency is held cfg_dwell+1 cycles
//   phase_inc/phase_en : feed the phase accumulator
//   busy, done, err    : sweep status
// Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface dds_sweep_ctrl_if #(
   parameter int INC_W   = dds_pkg::INC_W,
   parameter int DWELL_W = dds_pkg::DWELL_W
);

   logic               start;
   logic               stop;
   logic               cfg_mode;
   logic [INC_W-1:0]   cfg_f_start;
   logic [INC_W-1:0]   cfg_f_stop;
   logic [INC_W-1:0]   cfg_f_step;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [INC_W-1:0]   phase_inc;
   logic               phase_en;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      output start, stop, cfg_mode, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell,
      input  phase_inc, phase_en, busy, done, err
   );

   modport slave (
      input  start, stop, cfg_mode, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell,
      output phase_inc, phase_en, busy, done, err
   );

endinterface : dds_sweep_ctrl_if

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Counts cycles spent on the current frequency.
//   clk, rst : clock and synchronous active-high reset
//   clear    : forces the count to zero (priority over enable)
//   enable   : count one cycle
//   load     : dwell value; expiry happens when the count equals it
//   expire   : high in the cycle the count equals load while enabled; the
//              count wraps to zero at that edge, so each frequency lasts
//              exactly load+1 enabled cycles
// -----------------------------------------------------------------------------
module dwell_timer #(
   parameter int DWELL_W = dds_pkg::DWELL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               enable,
   input  logic [DWELL_W-1:0] load,
   output logic               expire
);

   logic [DWELL_W-1:0] count_q;
   logic [DWELL_W-1:0] count_d;
   logic               expire_s;

   // Expiry detect and next-count selection
   always_comb begin
      expire_s = 1'b0;
      count_d  = count_q;
      if (clear) begin
         count_d = {DWELL_W{1'b0}};
      end else if (enable) begin
         if (count_q == load) begin
            expire_s = 1'b1;
            count_d  = {DWELL_W{1'b0}};
         end else begin
            count_d = count_q + {{(DWELL_W-1){1'b0}}, 1'b1};
         end
      end else begin
         count_d = count_q;
      end
   end

   // Dwell count register
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= {DWELL_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   // The compare is taken from a registered count, so the pulse is clean
   assign expire = expire_s;

endmodule : dwell_timer

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
// Frequency-sweep controller for the phase-accumulator / sine-ROM generator.
// Steps phase_inc from f_start to f_stop by f_step, holding each value for
// dwell+1 cycles, either once (MODE_SINGLE) or as a continuous triangle
// (MODE_CONT). Config is captured at start and ignored while busy.
//   sys_clk : system clock
//   sys_rst : synchronous reset, active-high
//   bus     : dds_sweep_ctrl_if.slave (commands, config, outputs)
// All outputs are registered.
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
   parameter int INC_W   = dds_pkg::INC_W,
   parameter int DWELL_W = dds_pkg::DWELL_W
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   dds_sweep_ctrl_if.slave  bus
);

   import dds_pkg::*;

   // Sweep state and registered outputs
   state_e             state_q,     state_d;
   logic [INC_W-1:0]   phase_inc_q, phase_inc_d;
   logic               phase_en_q,  phase_en_d;
   logic               busy_q,      busy_d;
   logic               done_q,      done_d;
   logic               err_q,       err_d;

   // Shadow copy of the configuration taken at start
   logic               mode_q,      mode_d;
   logic [INC_W-1:0]   f_start_q,   f_start_d;
   logic [INC_W-1:0]   f_stop_q,    f_stop_d;
   logic [INC_W-1:0]   f_step_q,    f_step_d;
   logic [DWELL_W-1:0] dwell_q,     dwell_d;

   // Step arithmetic, one bit wider so neither direction can wrap
   logic [INC_W:0]     up_sum_s;
   logic [INC_W:0]     dn_diff_s;
   logic [INC_W-1:0]   up_next_s;
   logic [INC_W-1:0]   dn_next_s;

   logic               tmr_clear_s;
   logic               tmr_enable_s;
   logic               expire_s;

   function automatic logic cfg_legal(
      input logic [INC_W-1:0] f_start,
      input logic [INC_W-1:0] f_stop,
      input logic [INC_W-1:0] f_step
   );
      return (f_step != {INC_W{1'b0}}) && (f_start <= f_stop);
   endfunction

   // The timer idles at zero so every sweep begins with a full dwell
   assign tmr_clear_s  = (state_q == ST_IDLE);
   assign tmr_enable_s = (state_q != ST_IDLE);

   dwell_timer #(
      .DWELL_W (DWELL_W)
   ) u_dwell_timer (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .clear  (tmr_clear_s),
      .enable (tmr_enable_s),
      .load   (dwell_q),
      .expire (expire_s)
   );

   // Saturating next frequency in each direction from the current output.
   // These also serve the turnarounds: at f_start up_next is
   // min(f_start+f_step, f_stop), at f_stop dn_next is max(f_stop-f_step, f_start).
   always_comb begin
      up_sum_s  = {1'b0, phase_inc_q} + {1'b0, f_step_q};
      dn_diff_s = {1'b0, phase_inc_q} - {1'b0, f_step_q};
      if (up_sum_s > {1'b0, f_stop_q}) begin
         up_next_s = f_stop_q;
      end else begin
         up_next_s = up_sum_s[INC_W-1:0];
      end
      // MSB set means the subtraction borrowed below zero
      if (dn_diff_s[INC_W] || (dn_diff_s[INC_W-1:0] < f_start_q)) begin
         dn_next_s = f_start_q;
      end else begin
         dn_next_s = dn_diff_s[INC_W-1:0];
      end
   end

   // Next-state and output logic of the sweep FSM
   always_comb begin
      state_d     = state_q;
      phase_inc_d = phase_inc_q;
      phase_en_d  = phase_en_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      mode_d      = mode_q;
      f_start_d   = f_start_q;
      f_stop_d    = f_stop_q;
      f_step_d    = f_step_q;
      dwell_d     = dwell_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.stop) begin
               mode_d    = bus.cfg_mode;
               f_start_d = bus.cfg_f_start;
               f_stop_d  = bus.cfg_f_stop;
               f_step_d  = bus.cfg_f_step;
               dwell_d   = bus.cfg_dwell;
               if (cfg_legal(bus.cfg_f_start, bus.cfg_f_stop, bus.cfg_f_step)) begin
                  state_d     = ST_UP;
                  phase_inc_d = bus.cfg_f_start;
                  phase_en_d  = 1'b1;
                  busy_d      = 1'b1;
               end else begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_UP: begin
            if (bus.stop) begin
               state_d     = ST_IDLE;
               phase_inc_d = {INC_W{1'b0}};
               phase_en_d  = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
            end else if (expire_s) begin
               if (phase_inc_q != f_stop_q) begin
                  phase_inc_d = up_next_s;
               end else if (mode_q == MODE_CONT) begin
                  state_d     = ST_DOWN;
                  phase_inc_d = dn_next_s;
               end else begin
                  state_d     = ST_IDLE;
                  phase_inc_d = {INC_W{1'b0}};
                  phase_en_d  = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
               end
            end else begin
               state_d = ST_UP;
            end
         end

         ST_DOWN: begin
            if (bus.stop) begin
               state_d     = ST_IDLE;
               phase_inc_d = {INC_W{1'b0}};
               phase_en_d  = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
            end else if (expire_s) begin
               if (phase_inc_q != f_start_q) begin
                  phase_inc_d = dn_next_s;
               end else begin
                  state_d     = ST_UP;
                  phase_inc_d = up_next_s;
               end
            end else begin
               state_d = ST_DOWN;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            phase_inc_d = {INC_W{1'b0}};
            phase_en_d  = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State, output and shadow-config registers
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= ST_IDLE;
         phase_inc_q <= {INC_W{1'b0}};
         phase_en_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mode_q      <= MODE_SINGLE;
         f_start_q   <= {INC_W{1'b0}};
         f_stop_q    <= {INC_W{1'b0}};
         f_step_q    <= {INC_W{1'b0}};
         dwell_q     <= {DWELL_W{1'b0}};
      end else begin
         state_q     <= state_d;
         phase_inc_q <= phase_inc_d;
         phase_en_q  <= phase_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         mode_q      <= mode_d;
         f_start_q   <= f_start_d;
         f_stop_q    <= f_stop_d;
         f_step_q    <= f_step_d;
         dwell_q     <= dwell_d;
      end
   end

   assign bus.phase_inc = phase_inc_q;
   assign bus.phase_en  = phase_en_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule : dds_sweep_ctrl

// File: tb/tb_dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
// Directed bench for dds_sweep_ctrl. Inputs change and outputs are sampled
// 1 ns after each rising edge; expected sequences are written out by hand.
// -----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

   import dds_pkg::*;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   int   tests_run    = 0;
   int   tests_failed = 0;

   dds_sweep_ctrl_if bus ();

   dds_sweep_ctrl dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   // 50 MHz clock
   always #10 sys_clk = ~sys_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic set_cfg(input logic mode, input int fs, input int fe, input int st, input int dw);
      bus.cfg_mode    = mode;
      bus.cfg_f_start = fs[INC_W-1:0];
      bus.cfg_f_stop  = fe[INC_W-1:0];
      bus.cfg_f_step  = st[INC_W-1:0];
      bus.cfg_dwell   = dw[DWELL_W-1:0];
   endtask

   // One-cycle start pulse; returns just after the accepting edge
   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
   endtask

   // Expect frequency f for n consecutive cycles while sweeping
   task automatic expect_hold(input string tag, input int f, input int n);
      for (int c = 0; c < n; c++) begin
         check_val({tag, ".inc"},  32'(bus.phase_inc), 32'(f));
         check_val({tag, ".en"},   32'(bus.phase_en),  32'd1);
         check_val({tag, ".busy"}, 32'(bus.busy),      32'd1);
         check_val({tag, ".done"}, 32'(bus.done),      32'd0);
         tick();
      end
   endtask

   task automatic expect_idle(input string tag, input logic dn, input logic er);
      check_val({tag, ".inc"},  32'(bus.phase_inc), 32'd0);
      check_val({tag, ".en"},   32'(bus.phase_en),  32'd0);
      check_val({tag, ".busy"}, 32'(bus.busy),      32'd0);
      check_val({tag, ".done"}, 32'(bus.done),      32'(dn));
      check_val({tag, ".err"},  32'(bus.err),       32'(er));
   endtask

   initial begin
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      set_cfg(MODE_SINGLE, 10, 40, 10, 3);
      tick();
      tick();
      sys_rst = 1'b0;
      expect_idle("reset", 1'b0, 1'b0);

      // Single sweep: 10,20,30,40 for 4 cycles each, then done
      set_cfg(MODE_SINGLE, 10, 40, 10, 3);
      pulse_start();
      expect_hold("single10", 10, 4);
      expect_hold("single20", 20, 4);
      expect_hold("single30", 30, 4);
      expect_hold("single40", 40, 4);
      expect_idle("single_done", 1'b1, 1'b0);
      tick();
      expect_idle("single_after", 1'b0, 1'b0);

      // Clamp at f_stop with dwell 0; restart accepted during the done cycle
      set_cfg(MODE_SINGLE, 10, 35, 10, 0);
      pulse_start();
      expect_hold("clamp10", 10, 1);
      expect_hold("clamp20", 20, 1);
      expect_hold("clamp30", 30, 1);
      expect_hold("clamp35", 35, 1);
      expect_idle("clamp_done", 1'b1, 1'b0);
      pulse_start();
      expect_hold("restart_in_done", 10, 1);
      pulse_stop();
      expect_idle("restart_stop", 1'b1, 1'b0);
      tick();

      // Continuous triangle with endpoints dwelt once per turnaround
      set_cfg(MODE_CONT, 10, 30, 10, 1);
      pulse_start();
      expect_hold("cont10a", 10, 2);
      expect_hold("cont20a", 20, 2);
      expect_hold("cont30a", 30, 2);
      expect_hold("cont20b", 20, 2);
      expect_hold("cont10b", 10, 2);
      expect_hold("cont20c", 20, 2);
      expect_hold("cont30b", 30, 2);
      expect_hold("cont20d", 20, 1);
      pulse_stop();
      expect_idle("cont_stop", 1'b1, 1'b0);
      tick();

      // Constant output when f_start == f_stop in continuous mode
      set_cfg(MODE_CONT, 25, 25, 5, 0);
      pulse_start();
      expect_hold("flat", 25, 6);
      pulse_stop();
      expect_idle("flat_stop", 1'b1, 1'b0);
      tick();

      // Abort in the 2nd cycle of the 20 dwell, then restart one cycle later
      set_cfg(MODE_SINGLE, 10, 40, 10, 3);
      pulse_start();
      expect_hold("abort10", 10, 4);
      expect_hold("abort20", 20, 1);
      check_val("abort20_2nd", 32'(bus.phase_inc), 32'd20);
      pulse_stop();
      expect_idle("abort_done", 1'b1, 1'b0);
      tick();
      expect_idle("abort_after", 1'b0, 1'b0);
      pulse_start();
      expect_hold("abort_restart", 10, 2);
      pulse_stop();
      tick();

      // Stop coinciding with dwell expiry wins
      set_cfg(MODE_SINGLE, 10, 40, 10, 1);
      pulse_start();
      expect_hold("coinc10", 10, 1);
      pulse_stop();
      expect_idle("coinc_stop", 1'b1, 1'b0);
      tick();

      // Illegal configs: start > stop, then zero step
      set_cfg(MODE_SINGLE, 50, 40, 10, 3);
      pulse_start();
      expect_idle("illegal_order", 1'b1, 1'b1);
      tick();
      expect_idle("illegal_order_after", 1'b0, 1'b0);
      set_cfg(MODE_SINGLE, 10, 40, 0, 3);
      pulse_start();
      expect_idle("illegal_step", 1'b1, 1'b1);
      tick();
      expect_idle("illegal_step_after", 1'b0, 1'b0);

      // Start together with stop is ignored; stop alone in idle does nothing
      set_cfg(MODE_SINGLE, 10, 40, 10, 3);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      expect_idle("start_and_stop", 1'b0, 1'b0);
      pulse_stop();
      expect_idle("stop_in_idle", 1'b0, 1'b0);

      // Reset mid-sweep: all outputs zero, no done pulse afterwards
      pulse_start();
      expect_hold("rst10", 10, 4);
      expect_hold("rst20", 20, 1);
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      expect_idle("rst_mid", 1'b0, 1'b0);
      tick();
      expect_idle("rst_after", 1'b0, 1'b0);

      // Config changes while busy are ignored
      set_cfg(MODE_SINGLE, 10, 40, 10, 3);
      pulse_start();
      expect_hold("iso10a", 10, 2);
      bus.cfg_f_stop = 10'd20;
      expect_hold("iso10b", 10, 2);
      expect_hold("iso20", 20, 4);
      expect_hold("iso30", 30, 4);
      expect_hold("iso40", 40, 4);
      expect_idle("iso_done", 1'b1, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_dds_sweep_ctrl

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep controller for the phase-accumulator/sine-ROM tone generator. It drives the generator's per-cycle phase increment and enable, stepping the tone frequency from a start value to a stop value in programmable increments. Each frequency is held for a programmable dwell time. Runs single-shot or as a continuous up/down triangle sweep. Configuration comes from switches/keys or a register block; outputs feed the accumulator directly.

Parameters:
INC_W, 10, width of frequency/phase-increment words (matches the 1024-entry sine table phase width)
DWELL_W, 16, width of dwell count

Ports:
sys_clk  in  1  system clock (50 MHz)
sys_rst  in  1  synchronous reset, active-high
start  in  1  begin sweep; sampled in IDLE only
stop  in  1  abort sweep; priority over all other events
cfg_mode  in  1  0 = single up-sweep, 1 = continuous up/down
cfg_f_start  in  INC_W  first phase increment
cfg_f_stop  in  INC_W  last phase increment
cfg_f_step  in  INC_W  increment between frequencies
cfg_dwell  in  DWELL_W  each frequency is held cfg_dwell+1 cycles
phase_inc  out  INC_W  phase increment to accumulator
phase_en  out  1  accumulator advance enable
busy  out  1  sweep active
done  out  1  one-cycle pulse at sweep end (normal, abort or error)
err  out  1  one-cycle pulse, illegal config at start

Behaviour:
- All outputs registered. Reset (sync, sys_rst=1 at an edge): state IDLE, phase_inc=0, phase_en=0, busy=0, done=0, err=0, dwell counter=0, shadow config cleared. Reset mid-sweep aborts immediately; no done pulse.
- States: IDLE, UP, DOWN.
- IDLE, start=1, stop=0: latch all cfg_* into shadow regs. cfg_* changes while busy are ignored.
  - Legal config (cfg_f_step!=0 and cfg_f_start<=cfg_f_stop): at the same edge go UP, with busy=1, phase_en=1, phase_inc=f_start and dwell counter=0. Latency is 1 cycle from start to first valid phase_inc.
  - Illegal config: stay IDLE; err=1 and done=1 for one cycle; busy stays 0.
- IDLE with start=1 and stop=1: start is ignored.
- Dwell: counter increments each cycle while in UP/DOWN. On count==dwell (expiry), counter returns to 0 and a step occurs. Each frequency is therefore output for exactly dwell+1 cycles, so dwell=0 steps every cycle.
- UP expiry:
  - If phase_inc!=f_stop: phase_inc <= min(phase_inc+f_step, f_stop). Compute in INC_W+1 bits; no wrap.
  - If phase_inc==f_stop and mode 0: go IDLE with phase_en=0, phase_inc=0, busy=0, done=1.
  - If phase_inc==f_stop and mode 1: go DOWN with phase_inc <= max(phase_inc−f_step, f_start). Compute signed/INC_W+1; no underflow.
- DOWN expiry:
  - If phase_inc!=f_start: phase_inc <= max(phase_inc−f_step, f_start).
  - If phase_inc==f_start: go UP with phase_inc <= min(f_start+f_step, f_stop).
- Endpoints are dwelt once per turnaround. When f_start==f_stop in mode 1, output stays constant indefinitely until stop.
- stop=1 in UP/DOWN: at the next edge go IDLE with phase_en=0, phase_inc=0, busy=0, done=1. This has priority over a coincident dwell expiry.
- stop in IDLE has no effect.
- done and err are never high for more than one cycle. A new start is accepted in the cycle in which done is high, since state is already IDLE.

Decomposition:
- Shared package dds_pkg: state encoding constants (ST_IDLE, ST_UP, ST_DOWN), default INC_W=10 and DWELL_W=16, MODE_SINGLE/MODE_CONT constants. The tone generator uses the same INC_W constant.
- One sub-module: dwell_timer. It has clear, enable, DWELL_W load value and an expire pulse output. The saturating step arithmetic stays in the top module.

Test Plan:
- Single sweep. Config: mode0, start=10, stop=40, step=10, dwell=3. Pulse start. Required: phase_inc 10,20,30,40, each for 4 cycles with phase_en=1. Then phase_en=0, phase_inc=0, busy=0 and done=1 for 1 cycle, 17 edges after start.
- Clamp. Config: start=10, stop=35, step=10, dwell=0. Required: phase_inc 10,20,30,35, one cycle each, then done.
- Continuous. Config: mode1, start=10, stop=30, step=10, dwell=1. Required: phase_inc sequence 10,20,30,20,10,20,30,…, each for 2 cycles. busy stays 1 and done is never asserted.
- Abort. Assert stop during the 2nd cycle of the 20 dwell from the first scenario. Required: next cycle phase_en=0, phase_inc=0, busy=0, done=1 for 1 cycle. A start 1 cycle later restarts from 10.
- Illegal config. (a) start=50, stop=40; (b) step=0. Pulse start each time. Required: err=1 and done=1 for exactly 1 cycle; busy and phase_en remain 0.
- Reset and config isolation. Assert sys_rst mid-sweep: the next cycle has all outputs 0 and no done pulse. Separately, change cfg_f_stop from 40 to 20 mid-sweep: the sweep still ends at 40.
